// File: rtl/sat_acc_pkg.sv
// sat_acc_pkg: shared types for the signed saturating accumulator
package sat_acc_pkg;
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/sat_add.sv
// sat_add: combinational two's-complement adder that clamps on signed overflow
module sat_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);
    logic [WIDTH-1:0] raw;
    assign raw      = a + b;
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    // Overflow direction follows the shared operand sign
    assign sum      = overflow ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : raw;
endmodule

// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator: per-frame saturating sum with sticky overflow and event counter
module signed_sat_accumulator
    import sat_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_cnt
);
    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_eff, sum;
    logic             sticky, sticky_eff, ovf, xfer;
    // A clear in ACC makes the concurrent beat the first of a fresh frame
    assign acc_eff    = clear ? '0 : acc;
    assign sticky_eff = clear ? 1'b0 : sticky;
    assign xfer       = in_valid && in_ready;
    sat_add #(.WIDTH(WIDTH)) u_add (
        .a        (acc_eff),
        .b        (in_data),
        .sum      (sum),
        .overflow (ovf)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (state == ACC) state_next = (xfer && in_last) ? HOLD : ACC;
        else              state_next = out_ready ? ACC : HOLD;
    end
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sticky  <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
            ovf_cnt <= '0;
        end else if (state == ACC) begin
            if (xfer) begin
                if (ovf && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + 1'b1;
                if (in_last) begin
                    out_sum <= sum;
                    out_ovf <= sticky_eff | ovf;
                    acc     <= '0;
                    sticky  <= 1'b0;
                end else begin
                    acc    <= sum;
                    sticky <= sticky_eff | ovf;
                end
            end else if (clear) begin
                acc    <= '0;
                sticky <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb_signed_sat_accumulator: directed frames with hand-computed sums and counters
module tb_signed_sat_accumulator;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [3:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              clear = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [3:0] out_sum;
    logic              out_ovf;
    logic [7:0]        ovf_cnt;
    int                errors = 0;
    int                checks = 0;

    signed_sat_accumulator #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input logic signed [3:0] d, input logic last, input logic clr);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("take_in_ready", in_ready, 1);
        chk("take_out_valid", out_valid, 0);
    endtask

    task automatic result(input string tag, input int s, input int o, input int c);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, $signed(out_sum), s);
        chk({tag, "_ovf"}, out_ovf, o);
        chk({tag, "_cnt"}, ovf_cnt, c);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", $signed(out_sum), 0);
        chk("rst_cnt", ovf_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        send(3, 0, 0); send(2, 0, 0); send(1, 1, 0);
        result("f321", 6, 0, 0);
        chk("f321_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", $signed(out_sum), 6);
        end
        take();

        send(4, 0, 0); send(7, 1, 0);
        result("pos_sat", 7, 1, 1);
        take();

        send(-4, 0, 0); send(-7, 1, 0);
        result("neg_sat", -8, 1, 2);
        take();

        send(7, 0, 0); send(7, 0, 0); send(-8, 1, 0);
        result("f77m8", -1, 1, 3);
        take();

        send(-5, 1, 0);
        result("single", -5, 0, 3);
        take();

        send(5, 0, 0); send(6, 0, 0); send(2, 1, 1);
        result("clear", 2, 0, 4);
        take();

        send(3, 1, 0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        result("hold_clear", 3, 0, 4);
        take();

        send(5, 0, 0); send(1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", $signed(out_sum), 0);
        chk("mid_rst_ovf", out_ovf, 0);
        chk("mid_rst_cnt", ovf_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        send(2, 1, 0);
        result("post_rst", 2, 0, 0);
        take();

        for (int i = 0; i < 300; i++) send(7, 0, 0);
        chk("cnt_sat", ovf_cnt, 255);
        send(7, 1, 0);
        result("cnt_hold", 7, 1, 255);
        take();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signed_sat_accumulator.md
SIGNED_SAT_ACCUMULATOR -- requirements
Module: signed_sat_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the two's-complement data width of input samples and the accumulated result.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the overflow event counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an input sample is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: signed input sample.
REQ-008 SHALL have port in_last, input, 1 bit: the sample is the final beat of a frame.
REQ-009 SHALL have port clear, input, 1 bit: synchronously abandons the current partial frame.
REQ-010 SHALL have port out_valid, output, 1 bit: a frame result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_sum, output, WIDTH bits: signed, saturated frame sum.
REQ-013 SHALL have port out_ovf, output, 1 bit: at least one saturation occurred within the frame.
REQ-014 SHALL have port ovf_cnt, output, CNT_W bits: total saturation events since reset.

Function
REQ-015 SHALL implement a two-state FSM: ACC (accumulating) and HOLD (result pending).
REQ-016 SHALL drive in_ready=1 only in ACC, and out_valid=1 only in HOLD.
REQ-017 SHALL, on each ACC transfer (in_valid and in_ready), compute acc+in_data; if both operands have equal sign and the WIDTH-bit result sign differs, it SHALL saturate to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) according to operand sign.
REQ-018 SHALL set an internal sticky flag on any saturating transfer and increment ovf_cnt by 1, holding ovf_cnt at all-ones (never wrapping).
REQ-019 SHALL, on a transfer with in_last=1, load out_sum with the saturated sum and out_ovf with sticky OR current overflow, zero acc and sticky, and enter HOLD; the result SHALL be visible the cycle after the last beat.
REQ-020 SHALL, in HOLD, keep out_sum and out_ovf stable until out_ready=1, then return to ACC on the next edge.
REQ-021 SHALL treat a single-beat frame (in_last on first beat) as sum = in_data with no overflow.
REQ-022 SHALL, when clear=1 in ACC, zero acc and sticky; a simultaneous transfer SHALL be processed with acc taken as 0 (first beat of a new frame), including in_last handling.
REQ-023 SHALL ignore clear in HOLD; ovf_cnt SHALL be unaffected by clear.

Reset
REQ-024 SHALL, on rst, immediately set state=ACC, acc=0, sticky=0, out_sum=0, out_ovf=0, ovf_cnt=0; therefore in_ready=1 and out_valid=0.
REQ-025 SHALL discard any partial frame or pending result when rst is asserted mid-operation.

Structure
REQ-026 SHALL place the FSM state enum (ACC, HOLD) in shared package sat_acc_pkg.
REQ-027 SHALL implement the combinational saturating adder as sub-module sat_add, with ports a, b, sum, overflow, parameterised by WIDTH.

Verification
REQ-028 SHALL cover: frame 3,2,1(last) -> out_sum=6, out_ovf=0, ovf_cnt unchanged.
REQ-029 SHALL cover: frame 4,7(last) -> out_sum=7, out_ovf=1, ovf_cnt+1; frame -4,-7(last) -> out_sum=-8, out_ovf=1.
REQ-030 SHALL cover: frame 7,7,-8(last) -> 7+7 saturates to 7, then 7-8 gives out_sum=-1, out_ovf=1.
REQ-031 SHALL cover: out_ready held low 3 cycles in HOLD -> in_ready=0 and out_sum stable throughout; result taken on the 4th cycle, in_ready=1 on the next cycle.
REQ-032 SHALL cover: beats 5,6 then clear with beat 2(last) -> out_sum=2, out_ovf=0; rst mid-frame -> all outputs 0 and in_ready=1 immediately.
REQ-033 SHALL cover: 256+ saturating beats with CNT_W=8 -> ovf_cnt sticks at 255.
